// File: rtl/video_timing_pkg.sv
// Shared XGA 1024x768@60 timing constants, counter widths and the sync bundle type
// used by video_timing_gen and its output delay line.
package video_timing_pkg;

    localparam int CNT_W = 11;
    localparam int PIX_W = 10;

    localparam int XGA_H_ACTIVE = 1024;
    localparam int XGA_H_FP     = 24;
    localparam int XGA_H_SYNC   = 136;
    localparam int XGA_H_BP     = 160;
    localparam int XGA_H_TOTAL  = XGA_H_ACTIVE + XGA_H_FP + XGA_H_SYNC + XGA_H_BP;

    localparam int XGA_V_ACTIVE = 768;
    localparam int XGA_V_FP     = 3;
    localparam int XGA_V_SYNC   = 6;
    localparam int XGA_V_BP     = 29;
    localparam int XGA_V_TOTAL  = XGA_V_ACTIVE + XGA_V_FP + XGA_V_SYNC + XGA_V_BP;

    // Display-side bundle carried through the delay line, all active-high.
    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
    } vtg_sync_t;

endpackage

// File: rtl/vtg_delay_line.sv
// Parameterised shift register with asynchronous reset and shift enable.
// DEPTH = 0 degenerates to a straight wire.
module vtg_delay_line #(
    parameter int               WIDTH   = 3,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign o_q = i_d;
        end else begin : g_shift
            logic [WIDTH-1:0] r_stage [DEPTH];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) r_stage[i] <= RST_VAL;
                end else if (i_en) begin
                    r_stage[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
                end
            end

            assign o_q = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/video_timing_gen.sv
// Free-running raster timing source (default 1024x768@60) with registered decode
// and an OUT_DLY-deep display output path. Define VTG_CLKEN_EN to add the pix_ce enable.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = XGA_H_ACTIVE,
    parameter int H_FP     = XGA_H_FP,
    parameter int H_SYNC   = XGA_H_SYNC,
    parameter int H_BP     = XGA_H_BP,
    parameter int V_ACTIVE = XGA_V_ACTIVE,
    parameter int V_FP     = XGA_V_FP,
    parameter int V_SYNC   = XGA_V_SYNC,
    parameter int V_BP     = XGA_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int OUT_DLY  = 1
) (
    input  logic             clk,
    input  logic             rst,
`ifdef VTG_CLKEN_EN
    input  logic             pix_ce,
`endif
    output logic [PIX_W-1:0] pix_x,
    output logic [PIX_W-1:0] pix_y,
    output logic             video_active,
    output logic             vsync,
    output logic             hsync_int,
    output logic             line_start,
    output logic             frame_start,
    output logic             de_out,
    output logic             hsync_out,
    output logic             vsync_out
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] C_H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] C_HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] C_HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] C_H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] C_V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] C_VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] C_VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] C_V_LAST = CNT_W'(V_TOTAL - 1);

    generate
        if (H_ACTIVE > 1024 || V_ACTIVE > 1024 || OUT_DLY < 0 || OUT_DLY > 7 ||
            H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_cfg
            $error("video_timing_gen: unsupported timing configuration");
        end
    endgenerate

    logic             w_ce;
    logic [CNT_W-1:0] r_h_cnt;
    logic [CNT_W-1:0] r_v_cnt;
    logic             w_active;
    logic             w_hs;
    logic             w_vs;

    logic [PIX_W-1:0] r_pix_x;
    logic [PIX_W-1:0] r_pix_y;
    logic             r_active;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_line_start;
    logic             r_frame_start;

    vtg_sync_t        w_dly_in;
    vtg_sync_t        w_dly_out;

`ifdef VTG_CLKEN_EN
    assign w_ce = pix_ce;
`else
    assign w_ce = 1'b1;
`endif

    assign w_active = (r_h_cnt < C_H_ACT) && (r_v_cnt < C_V_ACT);
    assign w_hs     = (r_h_cnt >= C_HS_BEG) && (r_h_cnt < C_HS_END);
    // Depends on v only, so it can change only when the line wraps at h = 0.
    assign w_vs     = (r_v_cnt >= C_VS_BEG) && (r_v_cnt < C_VS_END);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_pix_x       <= '0;
            r_pix_y       <= '0;
            r_active      <= 1'b0;
            r_hsync       <= 1'b0;
            r_vsync       <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (w_ce) begin
            r_pix_x       <= w_active ? r_h_cnt[PIX_W-1:0] : '0;
            r_pix_y       <= w_active ? r_v_cnt[PIX_W-1:0] : '0;
            r_active      <= w_active;
            r_hsync       <= w_hs;
            r_vsync       <= w_vs;
            r_line_start  <= (r_h_cnt == '0);
            r_frame_start <= (r_h_cnt == '0) && (r_v_cnt == '0);
            if (r_h_cnt == C_H_LAST) begin
                r_h_cnt <= '0;
                r_v_cnt <= (r_v_cnt == C_V_LAST) ? '0 : r_v_cnt + 1'b1;
            end else begin
                r_h_cnt <= r_h_cnt + 1'b1;
            end
        end
    end

    assign w_dly_in.de = r_active;
    assign w_dly_in.hs = r_hsync;
    assign w_dly_in.vs = r_vsync;

    vtg_delay_line #(
        .WIDTH   ($bits(vtg_sync_t)),
        .DEPTH   (OUT_DLY),
        .RST_VAL ('0)
    ) u_out_dly (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_ce),
        .i_d  (w_dly_in),
        .o_q  (w_dly_out)
    );

    assign pix_x        = r_pix_x;
    assign pix_y        = r_pix_y;
    assign video_active = r_active;
    assign vsync        = r_vsync;
    assign hsync_int    = r_hsync;
    assign line_start   = r_line_start;
    assign frame_start  = r_frame_start;
    // Polarity is applied after the delay so reset stages read as deasserted.
    assign de_out       = w_dly_out.de;
    assign hsync_out    = w_dly_out.hs ^ ~HS_POL;
    assign vsync_out    = w_dly_out.vs ^ ~VS_POL;

endmodule
